// File: rtl/sha1_pkg.sv
// sha1_pkg: SHA-1 constants, FSM state type and per-round helper functions
package sha1_pkg;

   localparam int ROUNDS_PER_BLK = 80;

   localparam logic [31:0] K0 = 32'h5a827999;
   localparam logic [31:0] K1 = 32'h6ed9eba1;
   localparam logic [31:0] K2 = 32'h8f1bbcdc;
   localparam logic [31:0] K3 = 32'hca62c1d6;

   localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Choose, parity, majority, parity across the four 20-round ranges
   function automatic logic [31:0] f_sel(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
      return (t < 7'd20) ? ((b & c) | (~b & d)) :
             (t < 7'd40) ? (b ^ c ^ d) :
             (t < 7'd60) ? ((b & c) | (b & d) | (c & d)) :
                           (b ^ c ^ d);
   endfunction

   function automatic logic [31:0] k_sel(input logic [6:0] t);
      return (t < 7'd20) ? K0 : (t < 7'd40) ? K1 : (t < 7'd60) ? K2 : K3;
   endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round on the packed {a,b,c,d,e} state
module sha1_round
   import sha1_pkg::*;
(
   input  logic [159:0] st_i,
   input  logic [31:0]  w,
   input  logic [6:0]   t,
   output logic [159:0] st_o
);

   logic [31:0] a, b, c, d, e, temp;

   // Compress one schedule word into the working state
   always_comb begin
      {a, b, c, d, e} = st_i;
      temp = rotl(a, 5) + f_sel(t, b, c, d) + e + k_sel(t) + w;
      st_o = {temp, a, rotl(b, 30), c, d};
   end

endmodule

// File: rtl/sha1_round_engine.sv
// sha1_round_engine: runs all 80 SHA-1 rounds on one block, UNROLL rounds per clock
module sha1_round_engine
   import sha1_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [511:0] block_in,
   input  logic [159:0] h_in,
   output logic         busy,
   output logic         done,
   output logic [159:0] h_out
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
      $error("sha1_round_engine: UNROLL must be 1, 2, 4 or 5");
   end

   state_t         state_q, state_d;
   logic [6:0]     t_q, t_d;
   logic [159:0]   st_q, st_d;
   logic [31:0]    w_q [16];
   logic [31:0]    w_d [16];
   logic [159:0]   hreg_q, hreg_d;
   logic [159:0]   h_out_q, h_out_d;
   logic           done_q, done_d;
   logic [159:0]   chain_out;
   logic           last_group;

   // Chain of UNROLL rounds; each stage consumes the next word of the window
   for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
      logic [159:0] s_i, s_o;
      if (g == 0) begin : g_first
         assign s_i = st_q;
      end else begin : g_next
         assign s_i = g_rnd[g-1].s_o;
      end
      sha1_round u_round (
         .st_i (s_i),
         .w    (w_q[g]),
         .t    (t_q + 7'(g)),
         .st_o (s_o)
      );
   end

   assign chain_out  = g_rnd[UNROLL-1].s_o;
   assign last_group = (t_q == 7'(ROUNDS_PER_BLK - UNROLL));

   // State register with asynchronous abort
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         t_q     <= '0;
         st_q    <= '0;
         w_q     <= '{default: '0};
         hreg_q  <= '0;
         h_out_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         st_q    <= st_d;
         w_q     <= w_d;
         hreg_q  <= hreg_d;
         h_out_q <= h_out_d;
         done_q  <= done_d;
      end
   end

   // Next-state: accept in IDLE, leave ROUND after the last group, FINAL lasts one edge
   always_comb begin
      state_d = (state_q == IDLE)  ? (start ? ROUND : IDLE) :
                (state_q == ROUND) ? (last_group ? FINAL : ROUND) :
                                     IDLE;
   end

   // Datapath: load block, advance rounds and schedule window, add chaining value
   always_comb begin
      logic [31:0] x [16+UNROLL];
      for (int k = 0; k < 16; k++) x[k] = w_q[k];
      for (int k = 16; k < 16 + UNROLL; k++) x[k] = rotl(x[k-3] ^ x[k-8] ^ x[k-14] ^ x[k-16], 1);
      t_d     = t_q;
      st_d    = st_q;
      w_d     = w_q;
      hreg_d  = hreg_q;
      h_out_d = h_out_q;
      done_d  = 1'b0;
      if (state_q == IDLE && start) begin
         for (int k = 0; k < 16; k++) w_d[k] = block_in[511-32*k -: 32];
         hreg_d = h_in;
         st_d   = h_in;
         t_d    = '0;
      end
      if (state_q == ROUND) begin
         for (int k = 0; k < 16; k++) w_d[k] = x[k+UNROLL];
         st_d = chain_out;
         t_d  = t_q + 7'(UNROLL);
      end
      if (state_q == FINAL) begin
         for (int k = 0; k < 5; k++) h_out_d[159-32*k -: 32] = hreg_q[159-32*k -: 32] + st_q[159-32*k -: 32];
         done_d = 1'b1;
      end
   end

   // Outputs: busy whenever a block is in flight, done and digest straight from flops
   always_comb begin
      busy  = (state_q != IDLE);
      done  = done_q;
      h_out = h_out_q;
   end

endmodule

// File: tb/tb_sha1_round_engine.sv
// tb_sha1_round_engine: scoreboard bench over UNROLL = 1, 2, 4, 5 against a reference SHA-1
module tb_sha1_round_engine;

   localparam logic [159:0] IV_T   = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
   localparam logic [159:0] ABC_D  = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
   localparam logic [159:0] EMP_D  = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
   localparam logic [159:0] TWO_D  = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
   localparam logic [511:0] ABC_B  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMP_B  = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_B1 = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 32'h80000000, 32'h0};
   localparam logic [511:0] TWO_B2 = {448'h0, 64'd448};

   typedef struct {
      logic [159:0] h;
      int           c;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start_s [4];
   logic [511:0] blk_s   [4];
   logic [159:0] hin_s   [4];
   logic         busy_s  [4];
   logic         done_s  [4];
   logic [159:0] hout_s  [4];
   exp_t         exp_q   [4][$];
   int           cyc = 0;
   int           vectors = 0;
   int           miscompares = 0;

   // Free-running clock
   always #5 clk = ~clk;

   // Edge counter used to measure start-to-done latency
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int uf(input int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 5;
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [159:0] sha1_ref(input logic [511:0] blk, input logic [159:0] h);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, tmp;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
      {a, b, c, d, e} = h;
      for (int t = 0; t < 80; t++) begin
         case (t / 20)
            0:       begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            1:       begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            default: begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
         endcase
         tmp = rol(a, 5) + f + e + k + w[t];
         e = d; d = c; c = rol(b, 30); b = a; a = tmp;
      end
      return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
   endfunction

   task automatic chk(input string name, input int i, input logic [159:0] act, input logic [159:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s unroll=%0d: got %h, required %h", name, uf(i), act, req);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sha1_round_engine #(.UNROLL((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .start    (start_s[g]),
         .block_in (blk_s[g]),
         .h_in     (hin_s[g]),
         .busy     (busy_s[g]),
         .done     (done_s[g]),
         .h_out    (hout_s[g])
      );

      // Monitor: every done pops one expected digest and checks value and latency
      always @(negedge clk) begin
         exp_t e;
         if (done_s[g]) begin
            if (exp_q[g].size() == 0) begin
               chk("unexpected_done", g, 160'(done_s[g]), 160'd0);
            end else begin
               e = exp_q[g].pop_front();
               chk("digest", g, hout_s[g], e.h);
               chk("latency", g, 160'(cyc - e.c), 160'(80 / uf(g) + 1));
               chk("busy_at_done", g, 160'(busy_s[g]), 160'd0);
            end
         end
      end
   end

   task automatic go(input int i, input logic [511:0] b, input logic [159:0] h, input logic [159:0] e);
      start_s[i] = 1'b1;
      blk_s[i]   = b;
      hin_s[i]   = h;
      @(negedge clk);
      start_s[i] = 1'b0;
      for (int k = 0; k < 16; k++) blk_s[i][32*k +: 32] = $urandom;
      for (int k = 0; k < 5; k++) hin_s[i][32*k +: 32] = $urandom;
      exp_q[i].push_back('{h: e, c: cyc});
   endtask

   task automatic wait_done(input int i);
      for (int k = 0; k < 120 && !done_s[i]; k++) @(negedge clk);
      if (!done_s[i]) chk("done_timeout", i, 160'(done_s[i]), 160'd1);
   endtask

   task automatic wait_idle(input int i);
      for (int k = 0; k < 200 && exp_q[i].size() != 0; k++) @(negedge clk);
      if (exp_q[i].size() != 0) begin
         chk("idle_timeout", i, 160'(exp_q[i].size()), 160'd0);
         exp_q[i].delete();
      end
      @(negedge clk);
   endtask

   task automatic run_all(input int i);
      logic [511:0] b;
      logic [159:0] h, mid;
      go(i, ABC_B, IV_T, ABC_D);
      wait_idle(i);
      go(i, EMP_B, IV_T, EMP_D);
      wait_idle(i);
      mid = sha1_ref(TWO_B1, IV_T);
      go(i, TWO_B1, IV_T, mid);
      wait_done(i);
      go(i, TWO_B2, mid, TWO_D);
      wait_idle(i);
      go(i, ABC_B, IV_T, ABC_D);
      repeat (3) @(negedge clk);
      chk("busy_mid", i, 160'(busy_s[i]), 160'd1);
      start_s[i] = 1'b1;
      blk_s[i]   = EMP_B;
      hin_s[i]   = ~IV_T;
      @(negedge clk);
      start_s[i] = 1'b0;
      wait_idle(i);
      repeat (5) @(negedge clk);
      go(i, ABC_B, IV_T, ABC_D);
      repeat (37 / uf(i) - 1) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_busy", i, 160'(busy_s[i]), 160'd0);
      chk("rst_done", i, 160'(done_s[i]), 160'd0);
      chk("rst_hout", i, hout_s[i], 160'd0);
      exp_q[i].delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      go(i, ABC_B, IV_T, ABC_D);
      wait_idle(i);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
         for (int k = 0; k < 5; k++) h[32*k +: 32] = $urandom;
         go(i, b, h, sha1_ref(b, h));
         if (r < 2) wait_done(i);
      end
      wait_idle(i);
   endtask

   // Watchdog so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Stimulus: reset check, then every scenario on each UNROLL variant in turn
   initial begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start_s[i] = 1'b0;
         blk_s[i]   = '0;
         hin_s[i]   = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("reset_busy", i, 160'(busy_s[i]), 160'd0);
         chk("reset_done", i, 160'(done_s[i]), 160'd0);
         chk("reset_hout", i, hout_s[i], 160'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) run_all(i);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 4; i++) chk("queue_empty", i, 160'(exp_q[i].size()), 160'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
